// File: rtl/dot_product_sequencer_pkg.sv
// rtl/dot_product_sequencer_pkg.sv - shared state encoding and width helpers for the dot product sequencer
package dot_product_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t LOAD = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t OUT  = 2'd2;

    // Has to match the pipeline depth of the attached dotProduct instance.
    localparam int DP_LATENCY_DEFAULT = 2;

    function automatic int dp_res_width(input int a_w, input int b_w, input int extra_w);
        return a_w + b_w + extra_w;
    endfunction

endpackage

// File: rtl/dot_seq_vector_loader.sv
// rtl/dot_seq_vector_loader.sv - element counter and packed A/B operand registers
// Zero-fills the untouched tail of the vectors when a load ends early on last.
module dot_seq_vector_loader
    import dot_product_sequencer_pkg::*;
#(
    parameter int DIM          = 10,
    parameter int A_DATA_WIDTH = 16,
    parameter int B_DATA_WIDTH = 16,
    parameter int CNT_W        = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      xfer,
    input  logic                      last,
    input  logic [A_DATA_WIDTH-1:0]   elem_a,
    input  logic [B_DATA_WIDTH-1:0]   elem_b,
    output logic [A_DATA_WIDTH*DIM-1:0] vec_a,
    output logic [B_DATA_WIDTH*DIM-1:0] vec_b,
    output logic [CNT_W-1:0]          count,
    output logic                      done
);

    assign done = xfer && (last || (count == CNT_W'(DIM - 1)));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
            vec_a <= '0;
            vec_b <= '0;
        end else if (xfer) begin
            for (int i = 0; i < DIM; i++) begin
                if (CNT_W'(i) == count) begin
                    vec_a[i*A_DATA_WIDTH +: A_DATA_WIDTH] <= elem_a;
                    vec_b[i*B_DATA_WIDTH +: B_DATA_WIDTH] <= elem_b;
                end else if (last && (CNT_W'(i) > count)) begin
                    vec_a[i*A_DATA_WIDTH +: A_DATA_WIDTH] <= '0;
                    vec_b[i*B_DATA_WIDTH +: B_DATA_WIDTH] <= '0;
                end
            end
            count <= done ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dot_product_sequencer.sv
// rtl/dot_product_sequencer.sv - streams A/B pairs into dotProduct vectors and returns the result
// Optional DOTSEQ_ZERO_PAD_EN adds InLast for short, zero-padded vectors.
module dot_product_sequencer
    import dot_product_sequencer_pkg::*;
#(
    parameter int DIM             = 10,
    parameter int A_DATA_WIDTH    = 16,
    parameter int B_DATA_WIDTH    = 16,
    parameter int EXTRA_ADD_WIDTH = 4,
    parameter int RES_WIDTH       = dp_res_width(A_DATA_WIDTH, B_DATA_WIDTH, EXTRA_ADD_WIDTH),
    parameter int DP_LATENCY      = DP_LATENCY_DEFAULT
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        InValid,
    output logic                        InReady,
    input  logic [A_DATA_WIDTH-1:0]     InA,
    input  logic [B_DATA_WIDTH-1:0]     InB,
`ifdef DOTSEQ_ZERO_PAD_EN
    input  logic                        InLast,
`endif
    output logic [A_DATA_WIDTH*DIM-1:0] VecA,
    output logic [B_DATA_WIDTH*DIM-1:0] VecB,
    input  logic [RES_WIDTH-1:0]        DpResult,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [RES_WIDTH-1:0]        OutData,
    output logic                        Busy
);

    localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1;

    state_t           state;
    logic [3:0]       wait_cnt;
    logic [CNT_W-1:0] count;
    logic             xfer;
    logic             last;
    logic             load_done;

`ifdef DOTSEQ_ZERO_PAD_EN
    assign last = InLast;
`else
    assign last = 1'b0;
`endif

    assign InReady = (state == LOAD);
    assign xfer    = InValid && InReady;
    assign Busy    = (state != LOAD) || (count != '0);

    dot_seq_vector_loader #(
        .DIM          (DIM),
        .A_DATA_WIDTH (A_DATA_WIDTH),
        .B_DATA_WIDTH (B_DATA_WIDTH),
        .CNT_W        (CNT_W)
    ) u_loader (
        .Clock  (Clock),
        .Reset  (Reset),
        .xfer   (xfer),
        .last   (last),
        .elem_a (InA),
        .elem_b (InB),
        .vec_a  (VecA),
        .vec_b  (VecB),
        .count  (count),
        .done   (load_done)
    );

    // The wait counter spans DP_LATENCY+1 cycles so DpResult has settled before capture.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= LOAD;
            wait_cnt <= '0;
            OutData  <= '0;
            OutValid <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_done) begin
                        wait_cnt <= 4'(DP_LATENCY);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        OutData  <= DpResult;
                        OutValid <= 1'b1;
                        state    <= OUT;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                OUT: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        state    <= LOAD;
                    end
                end
                default: begin
                    OutValid <= 1'b0;
                    state    <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: doc/dot_product_sequencer.md
Name: dot_product_sequencer

Overview:
- Operand-side partner of the dotProduct datapath.
- Accepts A/B elements one pair per cycle over a valid/ready stream and packs them into the parallel A/B vectors that dotProduct consumes.
- Holds the vectors stable for the dotProduct pipeline latency, then captures DotProduct and returns it on a valid/ready result stream.
- Sits between the matrix-multiply row/column fetch logic and each dotProduct instance.

Parameters:
- DIM, 10, elements per vector.
- A_DATA_WIDTH, 16, bits per A element (unsigned).
- B_DATA_WIDTH, 16, bits per B element (unsigned).
- EXTRA_ADD_WIDTH, 4, accumulation guard bits; must be >= clog2(DIM).
- RES_WIDTH, A_DATA_WIDTH+B_DATA_WIDTH+EXTRA_ADD_WIDTH, result width.
- DP_LATENCY, 2, clock edges from a vector change to a valid DotProduct; range 0..15.

Ports:
- Clock  in  1  single system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- InValid  in  1  element pair valid.
- InReady  out  1  sequencer can accept an element pair.
- InA  in  A_DATA_WIDTH  A element.
- InB  in  B_DATA_WIDTH  B element.
- VecA  out  A_DATA_WIDTH*DIM  packed A vector to dotProduct.A.
- VecB  out  B_DATA_WIDTH*DIM  packed B vector to dotProduct.B.
- DpResult  in  RES_WIDTH  from dotProduct.DotProduct.
- OutValid  out  1  result valid.
- OutReady  in  1  result consumer ready.
- OutData  out  RES_WIDTH  captured dot product.
- Busy  out  1  high in any state other than LOAD with count 0.

Behaviour:
- Reset (synchronous, active-high): state=LOAD, element count=0, VecA=VecB=0, OutData=0, OutValid=0, InReady=1 on the cycle after the reset edge, Busy=0.
- Reset asserted mid-operation discards the partial vector or pending result with no output.
- Packing: the k-th accepted pair (k=0..DIM-1) is written to VecA[k*A_DATA_WIDTH +: A_DATA_WIDTH] and VecB[k*B_DATA_WIDTH +: B_DATA_WIDTH].
- Vector bits not yet written in the current load keep their previous value.
- FSM, 3 states:
  - LOAD: InReady=1. A transfer occurs on an edge with InValid&InReady; the pair is stored and count increments. On the transfer of element DIM-1: count resets to 0, the wait counter loads DP_LATENCY, and the state goes to WAIT.
  - WAIT: InReady=0 and VecA/VecB held stable. The wait counter decrements each edge. On the edge where the counter is 0, DpResult is registered into OutData, OutValid is set, and the state goes to OUT. WAIT lasts DP_LATENCY+1 cycles.
  - OUT: OutValid=1, InReady=0, OutData stable. On an edge with OutReady=1: OutValid clears and the state goes to LOAD.
- Latency: last element accepted at edge E0 → OutValid high after edge E0+DP_LATENCY+1.
- Throughput: one vector per DIM+DP_LATENCY+2 cycles when OutReady is held high.
- InValid while InReady=0 is ignored; the producer must hold its data.
- OutReady while OutValid=0 has no effect.
- Arithmetic is done in dotProduct. This block stores DpResult unmodified at RES_WIDTH and does no truncation.

Optional Feature:
- Macro: DOTSEQ_ZERO_PAD_EN.
- Defined:
  - Extra input port InLast (1 bit), sampled with each transfer.
  - A transfer with InLast=1 at element k<DIM-1 ends the load: elements k+1..DIM-1 of VecA/VecB are written to 0 on the same edge, and the state goes to WAIT.
  - InLast on element DIM-1, or InLast=0 there, behaves as the normal end of load.
- Not defined: no InLast port; exactly DIM transfers per vector.

Decomposition:
- Shared package/header:
  - State encoding localparams: LOAD=2'd0, WAIT=2'd1, OUT=2'd2.
  - RES_WIDTH derivation formula.
  - DP_LATENCY default, which must equal the dotProduct pipeline depth.
- One sub-module, dot_seq_vector_loader: element counter, packed A/B registers, last/pad logic.
- The FSM, wait counter and result register stay in the top-level module.

Test Plan (DIM=10, 16-bit, DP_LATENCY=2, real dotProduct attached):
- 10 pairs A=B=8, OutReady=1 → OutData=640, OutValid exactly 3 edges after the last transfer, held for 1 cycle.
- A=k+1, B=1 for k=0..9, OutReady held 0 for 5 cycles → OutData=55 stable, InReady=0 throughout; one result only.
- All elements 0xFFFF → OutData=42948362250 (36-bit, no overflow).
- Reset pulse after 4 transfers, then 10 pairs A=B=2 → OutData=40; no output from the aborted load; outputs 0 on the cycle after reset.
- InValid toggled randomly, back-to-back vectors → each result is correct and in order; no element lost or duplicated.
- With DOTSEQ_ZERO_PAD_EN: A=B=[1,2,3,4], InLast on 4th, after a prior all-9s vector → OutData=30; VecA/VecB upper 6 elements=0.
